duty_pwm_gen: RTL and testbench

Consumer side of the duty-setting register path: takes a 12-bit duty value and 12-bit period value written by the control side, and produces the PWM waveform that drives the output stage. Written values land in a pending buffer and are applied only at a period boundary, so no output period ever mixes old and new settings. Acknowledge and period-end strobes go back to the control side.

---
 rtl/duty_pwm_gen.sv | 102 ++++++++++
 tb/tb_duty_pwm_gen.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/duty_pwm_gen.sv
// PWM generator with a pending duty/period buffer. New settings take effect only
// at a period boundary, or at once while idle, and each application is acknowledged.
module duty_pwm_gen #(
    parameter int               WIDTH      = 12,
    parameter logic [WIDTH-1:0] RST_PERIOD = 12'hFFF
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Duty,
    input  logic [WIDTH-1:0] Period,
    input  logic             Load,
    input  logic             Run,
    output logic             PWM_out,
    output logic             Pend,
    output logic             Load_ack
);

    logic [WIDTH-1:0] cnt, duty_act, per_act, duty_pend, per_pend;
    logic             pend_valid;
    logic             run_q;

    logic [WIDTH-1:0] cnt_n, duty_n, per_n, duty_pend_n, per_pend_n;
    logic             pend_valid_n, ack_n, pwm_n, pend_n;
    logic             wrap;

    assign wrap = (cnt == per_act);

    always_comb begin
        cnt_n        = cnt;
        duty_n       = duty_act;
        per_n        = per_act;
        duty_pend_n  = duty_pend;
        per_pend_n   = per_pend;
        pend_valid_n = pend_valid;
        ack_n        = 1'b0;

        if (Load) begin
            duty_pend_n  = Duty;
            per_pend_n   = Period;
            pend_valid_n = 1'b1;
        end

        if (!Run) begin
            cnt_n = '0;
            if (Load) begin
                duty_n       = Duty;
                per_n        = Period;
                pend_valid_n = 1'b0;
                ack_n        = 1'b1;
            end else if (pend_valid) begin
                duty_n       = duty_pend;
                per_n        = per_pend;
                pend_valid_n = 1'b0;
                ack_n        = 1'b1;
            end
        end else if (!run_q) begin
            // First generate cycle always starts a fresh period; it is not a wrap.
            cnt_n = '0;
        end else if (wrap) begin
            cnt_n = '0;
            // A Load on this same edge refills the buffer for the next wrap.
            if (pend_valid) begin
                duty_n = duty_pend;
                per_n  = per_pend;
                ack_n  = 1'b1;
                if (!Load) pend_valid_n = 1'b0;
            end
        end else begin
            cnt_n = cnt + {{(WIDTH-1){1'b0}}, 1'b1};
        end

        pwm_n  = Run && (cnt_n < duty_n);
        pend_n = Run && (cnt_n == per_n);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt        <= '0;
            duty_act   <= '0;
            per_act    <= RST_PERIOD;
            duty_pend  <= '0;
            per_pend   <= '0;
            pend_valid <= 1'b0;
            run_q      <= 1'b0;
            PWM_out    <= 1'b0;
            Pend       <= 1'b0;
            Load_ack   <= 1'b0;
        end else begin
            cnt        <= cnt_n;
            duty_act   <= duty_n;
            per_act    <= per_n;
            duty_pend  <= duty_pend_n;
            per_pend   <= per_pend_n;
            pend_valid <= pend_valid_n;
            run_q      <= Run;
            PWM_out    <= pwm_n;
            Pend       <= pend_n;
            Load_ack   <= ack_n;
        end
    end

endmodule

// File: tb/tb_duty_pwm_gen.sv
// Directed bench for duty_pwm_gen: hand-planned stimulus with a per-cycle
// expectation of PWM_out, Pend and Load_ack.
module tb_duty_pwm_gen;

    logic        Clock;
    logic        Reset;
    logic [11:0] Duty;
    logic [11:0] Period;
    logic        Load;
    logic        Run;
    logic        PWM_out;
    logic        Pend;
    logic        Load_ack;

    int checks = 0;
    int errors = 0;

    duty_pwm_gen #(.WIDTH(12), .RST_PERIOD(12'hFFF)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Duty     (Duty),
        .Period   (Period),
        .Load     (Load),
        .Run      (Run),
        .PWM_out  (PWM_out),
        .Pend     (Pend),
        .Load_ack (Load_ack)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic e_pwm, input logic e_pend, input logic e_ack);
        chk({tag, " pwm"}, PWM_out, e_pwm);
        chk({tag, " pend"}, Pend, e_pend);
        chk({tag, " ack"}, Load_ack, e_ack);
    endtask

    // Clock through counter values from_c..to_c of a running period.
    task automatic seg(input string tag, input int from_c, input int to_c,
                       input int duty, input int per, input bit first_ack);
        for (int c = from_c; c <= to_c; c++) begin
            tick();
            chk3($sformatf("%s cnt=%0d", tag, c), (c < duty), (c == per),
                 (first_ack && (c == from_c)));
        end
    endtask

    initial begin
        Reset  = 1'b1;
        Run    = 1'b0;
        Load   = 1'b0;
        Duty   = '0;
        Period = '0;
        #3;
        chk3("reset", 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        Reset = 1'b0;

        // Defaults after reset: duty 0, period 4095
        Run = 1'b1;
        seg("A", 0, 4095, 0, 4095, 0);
        seg("A wrap", 0, 0, 0, 4095, 0);
        Run = 1'b0;
        tick();
        chk3("A idle", 1'b0, 1'b0, 1'b0);

        // Idle load applies at once
        Duty = 12'd3; Period = 12'd9; Load = 1'b1;
        tick();
        chk3("B idle load", 1'b0, 1'b0, 1'b1);
        Load = 1'b0;
        tick();
        chk3("B idle after", 1'b0, 1'b0, 1'b0);
        Run = 1'b1;
        seg("B p1", 0, 9, 3, 9, 0);
        seg("B p2", 0, 2, 3, 9, 0);

        // Load mid-period: current period untouched, duty > period afterwards
        Duty = 12'd6; Period = 12'd4; Load = 1'b1;
        seg("C load", 3, 3, 3, 9, 0);
        Load = 1'b0;
        seg("C rest", 4, 9, 3, 9, 0);
        seg("C new1", 0, 4, 6, 4, 1);
        seg("C new2", 0, 4, 6, 4, 0);

        // Load on the wrap edge, then overwritten before the next wrap
        Duty = 12'd2; Period = 12'd7; Load = 1'b1;
        seg("D wrapload", 0, 0, 6, 4, 0);
        Load = 1'b0;
        seg("D mid", 1, 2, 6, 4, 0);
        Duty = 12'd1; Period = 12'd3; Load = 1'b1;
        seg("D second", 3, 3, 6, 4, 0);
        Load = 1'b0;
        seg("D end", 4, 4, 6, 4, 0);
        seg("D new1", 0, 3, 1, 3, 1);
        seg("D new2", 0, 3, 1, 3, 0);
        Run = 1'b0;
        tick();
        chk3("D stop", 1'b0, 1'b0, 1'b0);

        // Single-clock period
        Duty = 12'd0; Period = 12'd0; Load = 1'b1;
        tick();
        chk3("E idle load", 1'b0, 1'b0, 1'b1);
        Load = 1'b0;
        Run  = 1'b1;
        repeat (3) seg("E d0", 0, 0, 0, 0, 0);
        Duty = 12'd1; Load = 1'b1;
        seg("E wrapload", 0, 0, 0, 0, 0);
        Load = 1'b0;
        seg("E apply", 0, 0, 1, 0, 1);
        repeat (3) seg("E d1", 0, 0, 1, 0, 0);

        // Reset mid-period with a pending value
        Run = 1'b0;
        Duty = 12'd8; Period = 12'd9; Load = 1'b1;
        tick();
        chk3("F idle load", 1'b0, 1'b0, 1'b1);
        Load = 1'b0;
        Run  = 1'b1;
        seg("F run", 0, 4, 8, 9, 0);
        Duty = 12'd2; Period = 12'd2; Load = 1'b1;
        seg("F pend", 5, 5, 8, 9, 0);
        Load = 1'b0;
        #2;
        Reset = 1'b1;
        Run   = 1'b0;
        #1;
        chk3("F async reset", 1'b0, 1'b0, 1'b0);
        #2;
        Reset = 1'b0;
        tick();
        chk3("F no pending", 1'b0, 1'b0, 1'b0);
        Run = 1'b1;
        seg("F defaults", 0, 10, 0, 4095, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
